// File: rtl/serial_comp_if.sv
// Handshake and operand/result bundle for serial_comp.
//   start, A, B, is_signed : request side, driven by the master
//   in_ready, busy, done   : status, driven by the comparator
//   EQ, GT, LT             : held result of the most recent compare
interface serial_comp_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             EQ;
  logic             GT;
  logic             LT;

  modport master (
    output start, A, B, is_signed,
    input  in_ready, busy, done, EQ, GT, LT
  );

  modport slave (
    input  start, A, B, is_signed,
    output in_ready, busy, done, EQ, GT, LT
  );
endinterface

// File: rtl/serial_comp.sv
// Serial magnitude comparator: walks the operands two bits per cycle, MSB pair
// first, and reports A==B / A>B / A<B after WIDTH/2 cycles.
//   clock : rising-edge system clock
//   reset : asynchronous, active-low
//   bus   : serial_comp_if slave (start/operands in, status and result out)
// Status outputs decode straight from the state register; results are
// registered and held until the next compare completes.
module serial_comp #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  serial_comp_if.slave  bus
);

  localparam int unsigned Pairs = WIDTH / 2;
  localparam int unsigned IdxW  = (Pairs > 1) ? $clog2(Pairs) : 1;
  localparam logic [IdxW-1:0] TopIdx = IdxW'(Pairs - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic             eq_acc_q, gt_acc_q;
  logic [IdxW-1:0]  idx_q;
  logic             eq_q, gt_q, lt_q;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic [1:0]       a_pair, b_pair;
  logic             eq_next, gt_next;

  // Current pair; for signed compares the sign bits are flipped so that a plain
  // unsigned compare of the top pair orders negatives below positives.
  always_comb begin
    a_shift = a_q >> {idx_q, 1'b0};
    b_shift = b_q >> {idx_q, 1'b0};
    a_pair  = a_shift[1:0];
    b_pair  = b_shift[1:0];
    if (signed_q && (idx_q == TopIdx)) begin
      a_pair[1] = ~a_pair[1];
      b_pair[1] = ~b_pair[1];
    end
    eq_next = eq_acc_q & (a_pair == b_pair);
    gt_next = gt_acc_q | (eq_acc_q & (a_pair > b_pair));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      idx_q    <= '0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            signed_q <= bus.is_signed;
            eq_acc_q <= 1'b1;
            gt_acc_q <= 1'b0;
            idx_q    <= TopIdx;
            state_q  <= StRun;
          end
        end
        StRun: begin
          eq_acc_q <= eq_next;
          gt_acc_q <= gt_next;
          if (idx_q == '0) begin
            // Last pair: publish the final flags as the held result.
            eq_q    <= eq_next;
            gt_q    <= gt_next;
            lt_q    <= ~eq_next & ~gt_next;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = (state_q == StIdle);
  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.EQ       = eq_q;
  assign bus.GT       = gt_q;
  assign bus.LT       = lt_q;

endmodule

// File: tb/tb_serial_comp.sv
module tb_serial_comp;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  serial_comp_if #(.WIDTH(32)) bus ();

  serial_comp #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-word compare, returns {eq, gt, lt}.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
    logic eq, gt;
    eq = (a == b);
    if (s) gt = ($signed(a) > $signed(b));
    else   gt = (a > b);
    return {eq, gt, !eq && !gt};
  endfunction

  function automatic logic [2:0] res();
    return {bus.EQ, bus.GT, bus.LT};
  endfunction

  // Presents a request and returns #1 after the accepting edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.A = a;
    bus.B = b;
    bus.is_signed = s;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_compare_case(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input string name);
    logic [2:0] exp;
    int n;
    bit seen;
    exp = model(a, b, s);
    do_start(a, b, s);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL %s accept: busy=%b in_ready=%b required busy=1 in_ready=0",
               name, bus.busy, bus.in_ready);
    seen = 0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen || n != 16) begin
      failures++;
      $display("FAIL %s latency: done after edge %0d (seen=%0d) required 16", name, n, seen);
    end
    checks++;
    if (res() !== exp) begin
      failures++;
      $display("FAIL %s result: A=%h B=%h s=%b EQGTLT=%b required %b",
               name, a, b, s, res(), exp);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || res() !== exp) begin
      failures++;
      $display("FAIL %s post_done: done=%b in_ready=%b EQGTLT=%b required 0 1 %b",
               name, bus.done, bus.in_ready, res(), exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || res() !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b EQGTLT=%b required 1 0 0 000",
               bus.in_ready, bus.busy, bus.done, res());
    end
  endtask

  task automatic test_equal();
    int bad;
    do_start(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    bad = 0;
    for (int e = 0; e < 16; e++) begin
      if (e > 0) begin
        @(posedge clock);
        #1;
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL equal_run edge %0d: busy=%b done=%b rdy=%b required 1 0 0",
                 e, bus.busy, bus.done, bus.in_ready);
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || res() !== 3'b100) begin
      failures++;
      $display("FAIL equal_done: done=%b busy=%b EQGTLT=%b required 1 0 100",
               bus.done, bus.busy, res());
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || res() !== 3'b100) begin
      failures++;
      $display("FAIL equal_idle: done=%b rdy=%b EQGTLT=%b required 0 1 100",
               bus.done, bus.in_ready, res());
    end
  endtask

  task automatic test_directed();
    test_compare_case(32'h80000000, 32'h7FFFFFFF, 1'b0, "msb_unsigned");
    test_compare_case(32'h80000000, 32'h7FFFFFFF, 1'b1, "msb_signed");
    test_compare_case(32'h00000001, 32'h00000002, 1'b0, "pair0_only");
    test_compare_case(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "neg_signed");
  endtask

  task automatic test_ignore_start();
    logic [2:0] prev;
    test_compare_case(32'h00000001, 32'h00000009, 1'b0, "ignore_pre");
    prev = res();
    do_start(32'd5, 32'd3, 1'b0);
    for (int e = 1; e <= 15; e++) begin
      if (e == 5) begin
        bus.A = 32'd1;
        bus.B = 32'd9;
        bus.start = 1'b1;
      end
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || res() !== prev) begin
        failures++;
        $display("FAIL ignore_hold edge %0d: busy=%b done=%b EQGTLT=%b required 1 0 %b",
                 e, bus.busy, bus.done, res(), prev);
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.done !== 1'b1 || res() !== 3'b010) begin
      failures++;
      $display("FAIL ignore_result: done=%b EQGTLT=%b required 1 010", bus.done, res());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || res() !== 3'b010) begin
        failures++;
        $display("FAIL ignore_idle_hold: rdy=%b EQGTLT=%b required 1 010", bus.in_ready, res());
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_start($urandom, $urandom, 1'b0);
    repeat (8) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || res() !== 3'b000) begin
      failures++;
      $display("FAIL midrun_reset: rdy=%b busy=%b done=%b EQGTLT=%b required 1 0 0 000",
               bus.in_ready, bus.busy, bus.done, res());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL midrun_no_done: done=%b busy=%b required 0 0", bus.done, bus.busy);
      end
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    test_compare_case(32'd2, 32'd2, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0] expq[$];
    logic [2:0] exp;
    logic [31:0] a, b;
    logic s;
    a = $urandom;
    b = $urandom;
    s = 1'($urandom);
    bus.A = a;
    bus.B = b;
    bus.is_signed = s;
    expq.push_back(model(a, b, s));
    bus.start = 1'b1;
    for (int n = 0; n < 54; n++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.in_ready !== ((n % 18) == 17) || bus.done !== ((n % 18) == 16) ||
          bus.busy !== ((n % 18) < 16)) begin
        failures++;
        $display("FAIL b2b_status n=%0d: rdy=%b done=%b busy=%b", n, bus.in_ready, bus.done,
                 bus.busy);
      end
      if ((n % 18) == 0) begin
        a = $urandom;
        b = (n == 18) ? a : $urandom;
        s = 1'($urandom);
        bus.A = a;
        bus.B = b;
        bus.is_signed = s;
        expq.push_back(model(a, b, s));
      end
      if (bus.done === 1'b1) begin
        exp = expq.pop_front();
        checks++;
        if (res() !== exp) begin
          failures++;
          $display("FAIL b2b_result n=%0d: EQGTLT=%b required %b", n, res(), exp);
        end
      end
    end
    bus.start = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    int sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      a = $urandom;
      s = 1'($urandom);
      case (sel)
        0: b = a;
        1: b = a ^ 32'($urandom_range(1, 3));
        2: b = $urandom;
        default: b = {~a[31], 31'($urandom)};
      endcase
      test_compare_case(a, b, s, "random");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.is_signed = 1'b0;
    #12;
    test_reset();
    @(posedge clock);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    test_equal();
    test_directed();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
